reg_file: RTL and testbench

Parametrised register file: the multi-entry successor to the single enabled 8-bit register. It holds DEPTH words of WIDTH bits, with one byte-strobed synchronous write port and two independent combinational read ports. An optional same-cycle write-through bypass and an optional hardwired-zero entry 0 are available. It is intended as the operand store for small datapaths and CPU-style lab designs.

---
 rtl/reg_file.sv | 82 ++++++++
 tb/tb_reg_file.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Register file with DEPTH words of WIDTH bits, one byte-strobed synchronous write
// port and two combinational read ports with optional write-through forwarding.
module reg_file #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [WIDTH/8-1:0]   wstrb,
  input  logic [ADDR_W-1:0]    raddr_a,
  output logic [WIDTH-1:0]     rdata_a,
  input  logic [ADDR_W-1:0]    raddr_b,
  output logic [WIDTH-1:0]     rdata_b
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = WIDTH / 8;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      mem_d[e] = mem_q[e];
      // Entry 0 never accepts data when it is the hardwired zero register.
      if (we && (waddr == ADDR_W'(e)) && !((ZERO_REG != 0) && (e == 0))) begin
        for (int l = 0; l < NB; l++) begin
          if (wstrb[l]) begin
            mem_d[e][8*l +: 8] = wdata[8*l +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (reset) begin
        mem_q[e] <= '0;
      end else begin
        mem_q[e] <= mem_d[e];
      end
    end
  end

  logic [1:0][ADDR_W-1:0] raddr_arr;
  logic [1:0][WIDTH-1:0]  rdata_arr;

  assign raddr_arr[0] = raddr_a;
  assign raddr_arr[1] = raddr_b;
  assign rdata_a      = rdata_arr[0];
  assign rdata_b      = rdata_arr[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rport
      logic [WIDTH-1:0] stored;
      logic [WIDTH-1:0] merged;
      logic             fwd;
      logic             is_zero;

      always_comb begin
        stored  = mem_q[raddr_arr[gi]];
        merged  = stored;
        for (int l = 0; l < NB; l++) begin
          if (wstrb[l]) begin
            merged[8*l +: 8] = wdata[8*l +: 8];
          end
        end
        fwd     = (BYPASS != 0) && we && !reset && (raddr_arr[gi] == waddr);
        is_zero = (ZERO_REG != 0) && (raddr_arr[gi] == '0);
      end

      assign rdata_arr[gi] = is_zero ? '0 : (fwd ? merged : stored);
    end
  endgenerate

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: default, no-bypass and zero-entry instances share
// one stimulus stream; each is checked against hand-computed values.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [1:0]  wstrb;
  logic [2:0]  raddr_a, raddr_b;
  logic [15:0] rd_a, rd_b, nb_a, nb_b, z_a, z_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_file #(.WIDTH(16), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) u_dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr_a(raddr_a), .rdata_a(rd_a), .raddr_b(raddr_b), .rdata_b(rd_b));

  reg_file #(.WIDTH(16), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) u_nb (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr_a(raddr_a), .rdata_a(nb_a), .raddr_b(raddr_b), .rdata_b(nb_b));

  reg_file #(.WIDTH(16), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) u_z (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr_a(raddr_a), .rdata_a(z_a), .raddr_b(raddr_b), .rdata_b(z_b));

  typedef struct {
    string       name;
    logic        rst;
    logic        wen;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [1:0]  ws;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] pre_a;
    logic [15:0] pre_b;
    logic [15:0] post_a;
    logic [15:0] post_b;
    logic [15:0] nb_pre_a;
  } vec_t;

  vec_t vecs[10];
  logic [15:0] model [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [2:0] wa,
                       input logic [15:0] wd, input logic [1:0] ws,
                       input logic [2:0] ra, input logic [2:0] rb);
    @(negedge clk);
    reset = r; we = w; waddr = wa; wdata = wd; wstrb = ws;
    raddr_a = ra; raddr_b = rb;
    #1;
  endtask

  task automatic finish_edge();
    @(posedge clk);
    #1;
    reset = 1'b0; we = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0] = '{"wr5_beef",     0, 1, 5, 16'hBEEF, 2'b11, 5, 5, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h0000};
    vecs[1] = '{"reset_clear",  1, 0, 0, 16'h0000, 2'b00, 5, 5, 16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000, 16'hBEEF};
    vecs[2] = '{"wr2_1234",     0, 1, 2, 16'h1234, 2'b11, 2, 5, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 16'h0000};
    vecs[3] = '{"wr2_lo_abcd",  0, 1, 2, 16'hABCD, 2'b01, 2, 2, 16'h12CD, 16'h12CD, 16'h12CD, 16'h12CD, 16'h1234};
    vecs[4] = '{"wr2_nostrb",   0, 1, 2, 16'hFFFF, 2'b00, 2, 2, 16'h12CD, 16'h12CD, 16'h12CD, 16'h12CD, 16'h12CD};
    vecs[5] = '{"we0_noop",     0, 0, 2, 16'h0000, 2'b11, 2, 2, 16'h12CD, 16'h12CD, 16'h12CD, 16'h12CD, 16'h12CD};
    vecs[6] = '{"wr3_00ff",     0, 1, 3, 16'h00FF, 2'b11, 3, 2, 16'h00FF, 16'h12CD, 16'h00FF, 16'h12CD, 16'h0000};
    vecs[7] = '{"bypass_hi",    0, 1, 3, 16'hA5A5, 2'b10, 3, 3, 16'hA5FF, 16'hA5FF, 16'hA5FF, 16'hA5FF, 16'h00FF};
    vecs[8] = '{"wr4_1234",     0, 1, 4, 16'h1234, 2'b11, 4, 3, 16'h1234, 16'hA5FF, 16'h1234, 16'hA5FF, 16'h0000};
    vecs[9] = '{"rst_vs_wr",    1, 1, 4, 16'h5555, 2'b11, 4, 3, 16'h1234, 16'hA5FF, 16'h0000, 16'h0000, 16'h1234};

    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
    raddr_a = '0; raddr_b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 16'h0, 2'b00, 3'(k), 3'(7 - k));
      chk($sformatf("rst_a%0d", k), rd_a, 16'h0000);
      chk($sformatf("rst_b%0d", 7 - k), rd_b, 16'h0000);
    end

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rst, vecs[i].wen, vecs[i].wa, vecs[i].wd, vecs[i].ws, vecs[i].ra, vecs[i].rb);
      chk({vecs[i].name, "_pre_a"},  rd_a, vecs[i].pre_a);
      chk({vecs[i].name, "_pre_b"},  rd_b, vecs[i].pre_b);
      chk({vecs[i].name, "_nb_pre"}, nb_a, vecs[i].nb_pre_a);
      finish_edge();
      chk({vecs[i].name, "_post_a"}, rd_a, vecs[i].post_a);
      chk({vecs[i].name, "_post_b"}, rd_b, vecs[i].post_b);
    end

    // Every entry must be clear after the reset that beat the write.
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 16'h0, 2'b00, 3'(k), 3'(k));
      chk($sformatf("postrst_a%0d", k), rd_a, 16'h0000);
    end

    // Hardwired zero entry.
    drive(0, 1, 0, 16'hFFFF, 2'b11, 0, 0);
    chk("zero_pre_a", z_a, 16'h0000);
    chk("zero_pre_b", z_b, 16'h0000);
    chk("nonzero_pre_a", rd_a, 16'hFFFF);
    finish_edge();
    chk("zero_post_a", z_a, 16'h0000);
    chk("zero_post_b", z_b, 16'h0000);
    chk("nonzero_post_a", rd_a, 16'hFFFF);
    drive(0, 1, 1, 16'hABCD, 2'b11, 1, 0);
    chk("zero_e1_pre", z_a, 16'hABCD);
    finish_edge();
    chk("zero_e1_post", z_a, 16'hABCD);
    chk("zero_e0_still", z_b, 16'h0000);

    // Dual-port sweep over a freshly filled file.
    drive(1, 0, 0, 16'h0, 2'b00, 0, 0);
    finish_edge();
    model[0] = 16'h0000;
    for (int k = 1; k < 8; k++) begin
      model[k] = 16'(16'h1111 * k);
      drive(0, 1, 3'(k), model[k], 2'b11, 0, 0);
      finish_edge();
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 16'h0, 2'b00, 3'(i), 3'(7 - i));
      chk($sformatf("sweep_a%0d", i), rd_a, model[i]);
      chk($sformatf("sweep_b%0d", 7 - i), rd_b, model[7 - i]);
      chk($sformatf("sweep_nb_a%0d", i), nb_a, model[i]);
    end
    drive(0, 0, 0, 16'h0, 2'b00, 5, 5);
    chk("same_addr_a", rd_a, 16'h5555);
    chk("same_addr_b", rd_b, 16'h5555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
